// File: rtl/gru_hidden_state_update.sv
// gru_hidden_state_update
//   Final stage of the GRU cell datapath. Per-neuron update-gate (z) and
//   candidate (n) values arrive in neuron order 0..H-1 and are blended with
//   the previous hidden state:
//     h_t[n] = (1 - z[n]) * n[n] + z[n] * h_prev[n]
//   evaluated as n + ((z * (h_prev - n)) >>> FRAC_BITS), saturated to the
//   signed DATA_WIDTH range. Results land in a shadow buffer. Once all H
//   elements are accepted, the whole buffer is committed to the hidden-state
//   bank in a single cycle. The bank feeds h_t_prev upstream for the next
//   timestep.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a timestep (IDLE only)
//   clear      zero hidden state, shadow buffer and step_count (IDLE only,
//              takes priority over start)
//   in_valid   z_in / n_in valid
//   in_ready   element accepted this cycle when in_valid is also high (RUN)
//   z_in       signed update-gate value, FRAC_BITS fractional bits
//   n_in       signed candidate value, FRAC_BITS fractional bits
//   h_state    committed hidden state, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   done       one-cycle pulse in the first cycle the new h_state is visible
//   busy       high in RUN or COMMIT
//   elem_idx   index of the next element expected
//   step_count committed timesteps since reset/clear (wraps)
module gru_hidden_state_update #(
  parameter int H          = 256,
  parameter int INT_BITS   = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DATA_WIDTH = INT_BITS + FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] z_in,
  input  logic signed [DATA_WIDTH-1:0] n_in,
  output logic [H*DATA_WIDTH-1:0]      h_state,
  output logic                         done,
  output logic                         busy,
  output logic [$clog2(H)-1:0]         elem_idx,
  output logic [31:0]                  step_count
);

  localparam int IDX_W = $clog2(H);
  // Full product width: DATA_WIDTH-bit z times (DATA_WIDTH+1)-bit diff.
  localparam int PW    = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  h_mem  [H];
  logic [DATA_WIDTH-1:0]  shadow [H];

  // Datapath signals
  logic [DATA_WIDTH-1:0]  h_prev;
  logic [DATA_WIDTH:0]    diff;
  logic signed [PW-1:0]   z_ext;
  logic signed [PW-1:0]   diff_ext;
  logic signed [PW-1:0]   n_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   scaled;
  logic signed [PW-1:0]   sum;
  logic [PW-DATA_WIDTH:0] sum_top;
  logic [DATA_WIDTH-1:0]  h_new;
  logic                   accept;

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int unsigned i = 0; i < H; i++) begin
      h_state[i*DATA_WIDTH +: DATA_WIDTH] = h_mem[i];
    end
  end

  // Blend arithmetic. Everything is sign-extended to the full product width
  // up front so the sum cannot wrap; saturation then only needs to check
  // that the bits above the result's sign bit are all copies of it.
  always_comb begin
    h_prev   = h_mem[elem_idx];
    diff     = {h_prev[DATA_WIDTH-1], h_prev} - {n_in[DATA_WIDTH-1], n_in};
    z_ext    = {{(DATA_WIDTH+1){z_in[DATA_WIDTH-1]}}, z_in};
    diff_ext = {{DATA_WIDTH{diff[DATA_WIDTH]}}, diff};
    n_ext    = {{(DATA_WIDTH+1){n_in[DATA_WIDTH-1]}}, n_in};
    prod     = z_ext * diff_ext;
    scaled   = prod >>> FRAC_BITS;
    sum      = n_ext + scaled;
    sum_top  = sum[PW-1:DATA_WIDTH-1];
    if ((&sum_top) || !(|sum_top)) begin
      h_new = sum[DATA_WIDTH-1:0];
    end else if (sum[PW-1]) begin
      h_new = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      h_new = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      elem_idx   <= '0;
      done       <= 1'b0;
      step_count <= '0;
      for (int unsigned i = 0; i < H; i++) begin
        h_mem[i]  <= '0;
        shadow[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            step_count <= '0;
            for (int unsigned i = 0; i < H; i++) begin
              h_mem[i]  <= '0;
              shadow[i] <= '0;
            end
          end else if (start) begin
            state    <= RUN;
            elem_idx <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            shadow[elem_idx] <= h_new;
            if (elem_idx == IDX_W'(H - 1)) begin
              elem_idx <= '0;
              state    <= COMMIT;
            end else begin
              elem_idx <= elem_idx + 1'b1;
            end
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < H; i++) begin
            h_mem[i] <= shadow[i];
          end
          done       <= 1'b1;
          step_count <= step_count + 32'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_hidden_state_update.sv
module tb_gru_hidden_state_update;

  localparam int H  = 4;
  localparam int DW = 24;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] z_in;
  logic signed [DW-1:0] n_in;
  logic [H*DW-1:0]      h_state;
  logic                 done;
  logic                 busy;
  logic [1:0]           elem_idx;
  logic [31:0]          step_count;

  gru_hidden_state_update #(
    .H         (H),
    .INT_BITS  (16),
    .FRAC_BITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z_in       (z_in),
    .n_in       (n_in),
    .h_state    (h_state),
    .done       (done),
    .busy       (busy),
    .elem_idx   (elem_idx),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_vec;
  int     n_bad;
  longint model_h [H];
  longint exp_q [$];
  longint step_exp;
  longint zs [H];
  longint ns [H];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint h_at(input int i);
    logic signed [DW-1:0] v;
    v = h_state[i*DW +: DW];
    return longint'(v);
  endfunction

  // Reference blend: floor shift on 64-bit signed, then clamp to Q16.8.
  function automatic longint blend(input longint z, input longint n, input longint hp);
    longint s;
    s = n + ((z * (hp - n)) >>> 8);
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_h_model(input string tag);
    for (int i = 0; i < H; i++) check(tag, h_at(i), model_h[i]);
  endtask

  // One full timestep using zs/ns. gaps inserts idle cycles with in_valid
  // low; disturb also pulses start/clear during those cycles.
  task automatic run_step(input bit gaps, input bit disturb);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_run", longint'(busy), 1);
    check("ready_run", longint'(in_ready), 1);
    for (int i = 0; i < H; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          start    = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
          clear    = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
          check("idx_hold", longint'(elem_idx), i);
          check("h_stable", h_at(i), model_h[i]);
        end
        start = 1'b0;
        clear = 1'b0;
      end
      check("idx_seq", longint'(elem_idx), i);
      in_valid = 1'b1;
      z_in     = DW'(zs[i]);
      n_in     = DW'(ns[i]);
      exp_q.push_back(blend(zs[i], ns[i], model_h[i]));
      tick();
    end
    in_valid = 1'b0;
    // COMMIT cycle: old state still visible
    check("idx_wrap", longint'(elem_idx), 0);
    check("ready_commit", longint'(in_ready), 0);
    check("busy_commit", longint'(busy), 1);
    check("done_early", longint'(done), 0);
    check_h_model("h_pre_commit");
    tick();
    check("done_pulse", longint'(done), 1);
    for (int i = 0; i < H; i++) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        model_h[i] = exp_q.pop_front();
        check("h_commit", h_at(i), model_h[i]);
      end
    end
    step_exp = (step_exp + 1) & 64'hFFFF_FFFF;
    check("step_count", longint'(step_count), step_exp);
    check("busy_idle", longint'(busy), 0);
    tick();
    check("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    step_exp = 0;
    for (int i = 0; i < H; i++) model_h[i] = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    z_in     = '0;
    n_in     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_done", longint'(done), 0);
    check("rst_idx", longint'(elem_idx), 0);
    check("rst_step", longint'(step_count), 0);
    check_h_model("rst_h");

    // Basic: z=0.5, n=1.0, h_prev=0 -> 0.5
    for (int i = 0; i < H; i++) begin zs[i] = 128; ns[i] = 256; end
    run_step(1'b0, 1'b0);
    for (int i = 0; i < H; i++) check("basic_const", h_at(i), 128);

    // Endpoints and floor rounding
    zs[0] = 0; ns[0] = -300;
    zs[1] = 256; ns[1] = 999;
    zs[2] = 1; ns[2] = 0;
    zs[3] = 1; ns[3] = 129;
    run_step(1'b0, 1'b0);
    check("end0_const", h_at(0), -300);
    check("end1_const", h_at(1), 128);
    check("end2_const", h_at(2), 0);
    check("end3_const", h_at(3), 128);

    // Preload extremes, then saturate both directions
    zs[0] = 0; ns[0] = 8388607;
    zs[1] = 0; ns[1] = -8388608;
    zs[2] = 64; ns[2] = 1000;
    zs[3] = -256; ns[3] = -77;
    run_step(1'b1, 1'b0);
    zs[0] = 512; ns[0] = -8388608;
    zs[1] = 512; ns[1] = 8388607;
    zs[2] = 300; ns[2] = -5000;
    zs[3] = -128; ns[3] = 4000;
    run_step(1'b1, 1'b1);
    check("sat_hi_const", h_at(0), 8388607);
    check("sat_lo_const", h_at(1), -8388608);

    // Random values with backpressure and start/clear noise
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < H; i++) begin
        zs[i] = longint'($urandom_range(0, 600)) - 300;
        ns[i] = longint'($urandom_range(0, 200000)) - 100000;
      end
      run_step(1'b1, 1'b1);
    end

    // Reset mid-RUN after two accepts
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      z_in = 24'sd100;
      n_in = 24'sd5000;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < H; i++) model_h[i] = 0;
    step_exp = 0;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_idx", longint'(elem_idx), 0);
    check("midrst_step", longint'(step_count), 0);
    check_h_model("midrst_h");
    tick();
    check("midrst_no_done", longint'(done), 0);
    for (int i = 0; i < H; i++) begin zs[i] = 128; ns[i] = 256 * (i + 1); end
    run_step(1'b1, 1'b0);

    // clear and start together: clear wins
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    for (int i = 0; i < H; i++) model_h[i] = 0;
    step_exp = 0;
    check("clr_busy", longint'(busy), 0);
    check("clr_step", longint'(step_count), 0);
    check_h_model("clr_h");
    tick();
    check("clr_busy_next", longint'(busy), 0);
    check("clr_no_done", longint'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
